// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-period helper.
package uart_pkg;

  localparam logic [2:0] ENC_IDLE      = 3'd0;
  localparam logic [2:0] ENC_START     = 3'd1;
  localparam logic [2:0] ENC_DATA      = 3'd2;
  localparam logic [2:0] ENC_STOP      = 3'd3;
  localparam logic [2:0] ENC_WAIT_IDLE = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ENC_IDLE,
    START     = ENC_START,
    DATA      = ENC_DATA,
    STOP      = ENC_STOP,
    WAIT_IDLE = ENC_WAIT_IDLE
  } uart_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with a configurable reset value.
module sync_2ff #(
  parameter int                 DATA_W  = 1,
  parameter logic [DATA_W-1:0]  RST_VAL = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] meta_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_p0 <= RST_VAL;
      q       <= RST_VAL;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver producing one-cycle byte / framing-error strobes.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around each mid-bit sample point.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int MID          = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
  localparam int START_DEC    = MID + 1;
`else
  localparam int START_DEC    = MID;
`endif
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_DEC);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 8) begin : g_bad_rate
    $error("uart_rx: CLK_HZ/BAUD must be at least 8");
  end

  logic        rx_s;
  logic        vld_p0;
  logic        vld_p1;
  logic        rx_prev;
  logic        fall;
  logic        sample_bit;
  logic        bit_strobe;
  logic [7:0]  shreg;
  uart_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]  idx;

  sync_2ff #(
    .DATA_W  (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // vld_p1 marks rx_s as a real line sample rather than the reset value,
  // so a line that is already low at reset release never looks like an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
      rx_prev <= vld_p1 & rx_s;
    end
  end

  assign fall = vld_p1 & rx_prev & ~rx_s;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_p1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk) begin
    hist_p1 <= {hist_p1[0], rx_s};
  end

  assign sample_bit = maj3(hist_p1[1], hist_p1[0], rx_s);
`else
  assign sample_bit = rx_s;
`endif

  assign bit_strobe = (state == DATA) && (cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (bit_strobe) begin
      shreg <= {sample_bit, shreg[7:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      rx_ack    <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      rx_data   <= 8'h00;
    end else begin
      rx_ack    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == START_LAST) begin
            cnt <= '0;
            if (!sample_bit) begin
              state <= DATA;
              idx   <= 3'd0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            idx <= idx + 1'b1;
            if (idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (sample_bit) begin
              rx_data <= shreg;
              rx_ack  <= 1'b1;
              state   <= IDLE;
              busy    <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // A held-low line (break) must rise before any new start is accepted.
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int MID = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  localparam int EXP_LAT = 2 + MID + 9 * CPB + 1 + 1 + MAJ;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] ack_q[$];
  int         ack_cyc_q[$];
  int         ack_busy_q[$];
  int         err_cnt = 0;
  int         last_err_cyc = 0;
  int         both_cnt = 0;
  logic       busy_prev = 1'b0;
  logic [7:0] last_good = 8'h00;

  uart_rx #(
    .CLK_HZ (1_600_000),
    .BAUD   (100_000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_ack) begin
      ack_q.push_back(rx_data);
      ack_cyc_q.push_back(cyc);
      ack_busy_q.push_back({30'd0, busy_prev, busy});
    end
    if (frame_err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (rx_ack && frame_err) both_cnt++;
    busy_prev = busy;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_v, input bit glitch,
                             input int ncyc, output int fall);
    logic [9:0] bits;
    bits = {stop_v, b, 1'b0};
    fall = -1;
    for (int j = 0; j < 10; j++) begin
      for (int t = 0; t < CPB; t++) begin
        if (j * CPB + t >= ncyc) return;
        @(negedge clk);
        if (j == 0 && t == 0) fall = cyc;
        rx = (glitch && j >= 1 && j <= 8 && t == MID + 1) ? ~bits[j] : bits[j];
      end
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (rx_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", rx_ack); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data); end
    reset = 1'b1;
    last_good = 8'h00;
    idle(8);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int n0, e0, fall, lat;
    n0 = ack_q.size(); e0 = err_cnt;
    drive_frame(8'hA5, 1'b1, 1'b0, 10 * CPB, fall);
    idle(20);
    n_tests++; if (ack_q.size() - n0 !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", ack_q.size() - n0); end
    n_tests++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL single_ferr: got %0d want 0", err_cnt - e0); end
    if (ack_q.size() > n0) begin
      lat = ack_cyc_q[n0] - fall;
      n_tests++; if (ack_q[n0] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", ack_q[n0]); end
      n_tests++; if (lat < EXP_LAT - 1 || lat > EXP_LAT + 1) begin n_fail++; $display("FAIL single_latency: got %0d want %0d+-1", lat, EXP_LAT); end
      n_tests++; if (ack_busy_q[n0] !== 2) begin n_fail++; $display("FAIL single_busy_fall: got prev/now %0b want 10", ack_busy_q[n0][1:0]); end
      last_good = 8'hA5;
    end
    n_tests++; if (rx_data !== last_good) begin n_fail++; $display("FAIL single_hold: got %h want %h", rx_data, last_good); end
  endtask

  task automatic test_back_to_back();
    int n0, f0, f1;
    n0 = ack_q.size();
    drive_frame(8'h00, 1'b1, 1'b0, 10 * CPB, f0);
    drive_frame(8'hFF, 1'b1, 1'b0, 10 * CPB, f1);
    idle(20);
    n_tests++; if (ack_q.size() - n0 !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", ack_q.size() - n0); end
    if (ack_q.size() >= n0 + 2) begin
      n_tests++; if (ack_q[n0] !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got %h want 00", ack_q[n0]); end
      n_tests++; if (ack_q[n0+1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got %h want ff", ack_q[n0+1]); end
      n_tests++; if (ack_cyc_q[n0+1] - ack_cyc_q[n0] !== 10 * CPB) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", ack_cyc_q[n0+1] - ack_cyc_q[n0], 10 * CPB); end
      last_good = 8'hFF;
    end
  endtask

  task automatic test_false_start();
    int n0, e0, fall;
    logic seen_busy;
    n0 = ack_q.size(); e0 = err_cnt;
    seen_busy = 1'b0;
    fall = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) fall = cyc;
      rx = (i < 5) ? 1'b0 : 1'b1;
      if (busy) seen_busy = 1'b1;
      if (cyc == fall + MID + 6) begin
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_clear: got %b want 0", busy); end
      end
    end
    n_tests++; if (seen_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_seen: got %b want 1", seen_busy); end
    n_tests++; if (ack_q.size() - n0 !== 0) begin n_fail++; $display("FAIL glitch_ack: got %0d want 0", ack_q.size() - n0); end
    n_tests++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_frame_err();
    int n0, e0, fall, lat;
    n0 = ack_q.size(); e0 = err_cnt;
    drive_frame(8'h3C, 1'b0, 1'b0, 10 * CPB, fall);
    repeat (40) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle(16);
    lat = last_err_cyc - fall;
    n_tests++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d want 1", err_cnt - e0); end
    n_tests++; if (lat < EXP_LAT - 1 || lat > EXP_LAT + 1) begin n_fail++; $display("FAIL ferr_latency: got %0d want %0d+-1", lat, EXP_LAT); end
    n_tests++; if (ack_q.size() - n0 !== 0) begin n_fail++; $display("FAIL ferr_no_ack: got %0d want 0", ack_q.size() - n0); end
    n_tests++; if (rx_data !== last_good) begin n_fail++; $display("FAIL ferr_data_kept: got %h want %h", rx_data, last_good); end
    drive_frame(8'h81, 1'b1, 1'b0, 10 * CPB, fall);
    idle(20);
    n_tests++; if (ack_q.size() - n0 !== 1) begin n_fail++; $display("FAIL ferr_recover_count: got %0d want 1", ack_q.size() - n0); end
    if (ack_q.size() > n0) begin
      n_tests++; if (ack_q[n0] !== 8'h81) begin n_fail++; $display("FAIL ferr_recover_data: got %h want 81", ack_q[n0]); end
      last_good = 8'h81;
    end
    n_tests++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL ferr_single: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_reset_midframe();
    int n0, e0, fall;
    n0 = ack_q.size(); e0 = err_cnt;
    drive_frame(8'h5A, 1'b1, 1'b0, 5 * CPB + MID, fall);
    @(negedge clk);
    reset = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h want 00", rx_data); end
    reset = 1'b1;
    last_good = 8'h00;
    idle(20);
    drive_frame(8'h12, 1'b1, 1'b0, 10 * CPB, fall);
    idle(20);
    n_tests++; if (ack_q.size() - n0 !== 1) begin n_fail++; $display("FAIL midrst_count: got %0d want 1", ack_q.size() - n0); end
    n_tests++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL midrst_ferr: got %0d want 0", err_cnt - e0); end
    if (ack_q.size() > n0) begin
      n_tests++; if (ack_q[n0] !== 8'h12) begin n_fail++; $display("FAIL midrst_data_after: got %h want 12", ack_q[n0]); end
      last_good = 8'h12;
    end
  endtask

  task automatic test_reset_line_low();
    int n0, e0, fall;
    logic seen_busy;
    n0 = ack_q.size(); e0 = err_cnt;
    seen_busy = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    last_good = 8'h00;
    repeat (40) begin
      @(negedge clk);
      rx = 1'b0;
      if (busy) seen_busy = 1'b1;
    end
    n_tests++; if (seen_busy !== 1'b0) begin n_fail++; $display("FAIL lowrst_busy: got %b want 0", seen_busy); end
    idle(20);
    drive_frame(8'h34, 1'b1, 1'b0, 10 * CPB, fall);
    idle(20);
    n_tests++; if (ack_q.size() - n0 !== 1) begin n_fail++; $display("FAIL lowrst_count: got %0d want 1", ack_q.size() - n0); end
    n_tests++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL lowrst_ferr: got %0d want 0", err_cnt - e0); end
    if (ack_q.size() > n0) begin
      n_tests++; if (ack_q[n0] !== 8'h34) begin n_fail++; $display("FAIL lowrst_data: got %h want 34", ack_q[n0]); end
      last_good = 8'h34;
    end
  endtask

  task automatic test_majority();
    int n0, fall;
    logic [7:0] exp_b;
    exp_b = (MAJ != 0) ? 8'h6E : ~8'h6E;
    n0 = ack_q.size();
    drive_frame(8'h6E, 1'b1, 1'b1, 10 * CPB, fall);
    idle(20);
    n_tests++; if (ack_q.size() - n0 !== 1) begin n_fail++; $display("FAIL vote_count: got %0d want 1", ack_q.size() - n0); end
    if (ack_q.size() > n0) begin
      n_tests++; if (ack_q[n0] !== exp_b) begin n_fail++; $display("FAIL vote_data: got %h want %h", ack_q[n0], exp_b); end
      last_good = exp_b;
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int n0, e0, exp_err, fall;
    logic [7:0] b;
    logic bad;
    n0 = ack_q.size(); e0 = err_cnt; exp_err = 0;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      drive_frame(b, ~bad, 1'b0, 10 * CPB, fall);
      if (bad) begin
        exp_err++;
        repeat ($urandom_range(0, 30)) begin
          @(negedge clk);
          rx = 1'b0;
        end
        idle($urandom_range(2, 6));
      end else begin
        exp_q.push_back(b);
        last_good = b;
        idle($urandom_range(0, 3));
      end
    end
    idle(30);
    n_tests++; if (ack_q.size() - n0 !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", ack_q.size() - n0, exp_q.size()); end
    n_tests++; if (err_cnt - e0 !== exp_err) begin n_fail++; $display("FAIL rand_ferr: got %0d want %0d", err_cnt - e0, exp_err); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (n0 + i < ack_q.size()) begin
        n_tests++; if (ack_q[n0+i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte%0d: got %h want %h", i, ack_q[n0+i], exp_q[i]); end
      end
    end
    n_tests++; if (rx_data !== last_good) begin n_fail++; $display("FAIL rand_hold: got %h want %h", rx_data, last_good); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_reset_midframe();
    test_reset_line_low();
    test_majority();
    test_random();
    n_tests++; if (both_cnt !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d want 0", both_cnt); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
